// File: rtl/freq_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : freq_mon_pkg
// Description : Shared types and helpers for the frequency lock monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package freq_mon_pkg;

  // Measurement sequencer states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Signed error needs one extra bit over the unsigned pulse count
  function automatic int err_width(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/freq_lock_channel.sv
`default_nettype none
// ============================================================================
// Module      : freq_lock_channel
// Description : One monitored channel: saturating pulse counter, result
//               capture, signed error / tolerance check and lock hysteresis.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_lock_channel
  import freq_mon_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int HYS_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_count_clr,
  input  logic                  i_count_en,
  input  logic                  i_capture,
  input  logic                  i_eval,
  input  logic                  i_hys_clr,
  input  logic                  i_pulse,
  input  logic [CNT_W-1:0]      i_target,
  input  logic [CNT_W-1:0]      i_tol,
  input  logic [HYS_W-1:0]      i_lock_thr,
  input  logic [HYS_W-1:0]      i_unlock_thr,
  output logic [CNT_W-1:0]      o_count,
  output logic [CNT_W:0]        o_err,
  output logic                  o_sat,
  output logic                  o_locked
);

  localparam int ERR_W = err_width(CNT_W);
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
  localparam logic [HYS_W-1:0] C_HYS_MAX = '1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [CNT_W-1:0] r_meas_cnt;
  logic [ERR_W-1:0] r_meas_err;
  logic             r_meas_sat;
  logic [HYS_W-1:0] r_good;
  logic [HYS_W-1:0] r_bad;
  logic             r_locked;

  logic             w_at_max;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_sat_next;
  logic [ERR_W-1:0] w_err;
  logic [ERR_W-1:0] w_abs;
  logic             w_in_tol;
  logic [HYS_W:0]   w_good_inc;
  logic [HYS_W:0]   w_bad_inc;

  // Count including this cycle's pulse; this is also what gets captured
  assign w_at_max   = (r_cnt == C_CNT_MAX);
  assign w_cnt_next = (i_pulse && !w_at_max) ? r_cnt + 1'b1 : r_cnt;
  assign w_sat_next = r_sat | (i_pulse & w_at_max);

  // Magnitude of count-target never exceeds 2^CNT_W-1, so it fits ERR_W bits
  assign w_err    = {1'b0, w_cnt_next} - {1'b0, i_target};
  assign w_abs    = w_err[ERR_W-1] ? (~w_err + 1'b1) : w_err;
  assign w_in_tol = !w_sat_next && (w_abs <= {1'b0, i_tol});

  assign w_good_inc = {1'b0, r_good} + 1'b1;
  assign w_bad_inc  = {1'b0, r_bad} + 1'b1;

  // Pulse counter: restarts on every capture so back-to-back windows lose no cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (i_count_clr || i_capture) begin
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (i_count_en) begin
      r_cnt <= w_cnt_next;
      r_sat <= w_sat_next;
    end
  end

  // Result capture at the last window cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_cnt <= '0;
      r_meas_err <= '0;
      r_meas_sat <= 1'b0;
    end else if (i_capture) begin
      r_meas_cnt <= w_cnt_next;
      r_meas_err <= w_err;
      r_meas_sat <= w_sat_next;
    end
  end

  // Lock hysteresis, updated together with the published result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_good   <= '0;
      r_bad    <= '0;
      r_locked <= 1'b0;
    end else if (i_hys_clr) begin
      r_good <= '0;
      r_bad  <= '0;
    end else if (i_eval) begin
      if (w_in_tol) begin
        r_bad  <= '0;
        r_good <= (r_good == C_HYS_MAX) ? r_good : w_good_inc[HYS_W-1:0];
        if (w_good_inc >= {1'b0, i_lock_thr}) r_locked <= 1'b1;
      end else begin
        r_good <= '0;
        r_bad  <= (r_bad == C_HYS_MAX) ? r_bad : w_bad_inc[HYS_W-1:0];
        if (w_bad_inc >= {1'b0, i_unlock_thr}) r_locked <= 1'b0;
      end
    end
  end

  assign o_count  = r_meas_cnt;
  assign o_err    = r_meas_err;
  assign o_sat    = r_meas_sat;
  assign o_locked = r_locked;

endmodule
`default_nettype wire

// File: rtl/freq_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : freq_lock_monitor
// Description : Multi-channel windowed edge counter with signed error against
//               a target and per-channel lock/unlock hysteresis.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_lock_monitor
  import freq_mon_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int WIN_W  = 16,
  parameter int HYS_W  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        cfg_oneshot,
  input  logic                        start,
  input  logic [WIN_W-1:0]            cfg_win_len,
  input  logic [CNT_W-1:0]            cfg_target,
  input  logic [CNT_W-1:0]            cfg_tol,
  input  logic [HYS_W-1:0]            cfg_lock_thr,
  input  logic [HYS_W-1:0]            cfg_unlock_thr,
  input  logic [NUM_CH-1:0]           edge_pulse,
  output logic                        busy,
  output logic                        meas_valid,
  output logic [NUM_CH*CNT_W-1:0]     meas_count,
  output logic [NUM_CH*(CNT_W+1)-1:0] meas_err,
  output logic [NUM_CH-1:0]           meas_sat,
  output logic [NUM_CH-1:0]           locked
);

  state_t           r_state;
  logic             r_busy;
  logic             r_meas_valid;
  logic [WIN_W-1:0] r_win_cnt;
  logic [WIN_W-1:0] r_win_len;
  logic [CNT_W-1:0] r_target;
  logic [CNT_W-1:0] r_tol;
  logic [HYS_W-1:0] r_lock_thr;
  logic [HYS_W-1:0] r_unlock_thr;
  logic             r_oneshot;

  logic             w_last;
  logic             w_capture;
  logic             w_count_clr;
  logic             w_count_en;
  logic             w_hys_clr;
  logic             w_idle_go;
  logic             w_load;

  assign w_last      = (r_state == ST_MEASURE) && (r_win_cnt == r_win_len - 1'b1);
  assign w_capture   = w_last && enable;
  assign w_count_en  = (r_state == ST_MEASURE);
  assign w_count_clr = (r_state != ST_MEASURE) || !enable;
  assign w_hys_clr   = !enable;
  assign w_idle_go   = enable && (!cfg_oneshot || start);

  // Config is sampled whenever a window is about to begin
  assign w_load = ((r_state == ST_IDLE) && w_idle_go) ||
                  ((r_state == ST_DONE) && enable && start) ||
                  (w_capture && !r_oneshot);

  // Shadow config so mid-window changes never disturb the running window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_len    <= WIN_W'(1);
      r_target     <= '0;
      r_tol        <= '0;
      r_lock_thr   <= HYS_W'(1);
      r_unlock_thr <= HYS_W'(1);
      r_oneshot    <= 1'b0;
    end else if (w_load) begin
      r_win_len    <= (cfg_win_len == '0) ? WIN_W'(1) : cfg_win_len;
      r_target     <= cfg_target;
      r_tol        <= cfg_tol;
      r_lock_thr   <= (cfg_lock_thr == '0) ? HYS_W'(1) : cfg_lock_thr;
      r_unlock_thr <= (cfg_unlock_thr == '0) ? HYS_W'(1) : cfg_unlock_thr;
      r_oneshot    <= cfg_oneshot;
    end
  end

  // Sequencer: window counter, busy flag and result strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_meas_valid <= 1'b0;
      r_win_cnt    <= '0;
    end else begin
      r_meas_valid <= w_capture;
      case (r_state)
        ST_IDLE: begin
          r_win_cnt <= '0;
          if (w_idle_go) begin
            r_state <= ST_MEASURE;
            r_busy  <= 1'b1;
          end
        end
        ST_MEASURE: begin
          if (!enable) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_win_cnt <= '0;
          end else if (w_last) begin
            r_win_cnt <= '0;
            if (r_oneshot) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_win_cnt <= '0;
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (start) begin
            r_state <= ST_MEASURE;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_busy    <= 1'b0;
          r_win_cnt <= '0;
        end
      endcase
    end
  end

  generate
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      freq_lock_channel #(
        .CNT_W (CNT_W),
        .HYS_W (HYS_W)
      ) u_ch (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_count_clr  (w_count_clr),
        .i_count_en   (w_count_en),
        .i_capture    (w_capture),
        .i_eval       (w_capture),
        .i_hys_clr    (w_hys_clr),
        .i_pulse      (edge_pulse[g]),
        .i_target     (r_target),
        .i_tol        (r_tol),
        .i_lock_thr   (r_lock_thr),
        .i_unlock_thr (r_unlock_thr),
        .o_count      (meas_count[g*CNT_W +: CNT_W]),
        .o_err        (meas_err[g*(CNT_W+1) +: (CNT_W+1)]),
        .o_sat        (meas_sat[g]),
        .o_locked     (locked[g])
      );
    end
  endgenerate

  assign busy       = r_busy;
  assign meas_valid = r_meas_valid;

endmodule
`default_nettype wire

// File: tb/tb_freq_lock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_freq_lock_monitor
// Description : Directed self-checking bench for freq_lock_monitor (CNT_W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_lock_monitor;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int WIN_W  = 16;
  localparam int HYS_W  = 4;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        enable = 1'b0;
  logic                        cfg_oneshot = 1'b0;
  logic                        start = 1'b0;
  logic [WIN_W-1:0]            cfg_win_len = '0;
  logic [CNT_W-1:0]            cfg_target = '0;
  logic [CNT_W-1:0]            cfg_tol = '0;
  logic [HYS_W-1:0]            cfg_lock_thr = '0;
  logic [HYS_W-1:0]            cfg_unlock_thr = '0;
  logic [NUM_CH-1:0]           edge_pulse = '0;
  logic                        busy;
  logic                        meas_valid;
  logic [NUM_CH*CNT_W-1:0]     meas_count;
  logic [NUM_CH*(CNT_W+1)-1:0] meas_err;
  logic [NUM_CH-1:0]           meas_sat;
  logic [NUM_CH-1:0]           locked;

  int total = 0;
  int bad   = 0;

  // Pulse pattern state: period per channel, extra odd-cycle pulses on ch0
  int  per [NUM_CH];
  int  x0 = 0;
  int  wc = 0;
  int  win = 1;
  int  start_at = -1;
  bit  act = 1'b0;

  always #5 clk = ~clk;

  freq_lock_monitor #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W),
    .WIN_W  (WIN_W),
    .HYS_W  (HYS_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .cfg_oneshot    (cfg_oneshot),
    .start          (start),
    .cfg_win_len    (cfg_win_len),
    .cfg_target     (cfg_target),
    .cfg_tol        (cfg_tol),
    .cfg_lock_thr   (cfg_lock_thr),
    .cfg_unlock_thr (cfg_unlock_thr),
    .edge_pulse     (edge_pulse),
    .busy           (busy),
    .meas_valid     (meas_valid),
    .meas_count     (meas_count),
    .meas_err       (meas_err),
    .meas_sat       (meas_sat),
    .locked         (locked)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt_of(input int i);
    return {24'd0, meas_count[i*CNT_W +: CNT_W]};
  endfunction

  function automatic logic [31:0] err_of(input int i);
    return {23'd0, meas_err[i*(CNT_W+1) +: (CNT_W+1)]};
  endfunction

  // Expected count and signed error (encoded in 9 bits) for channel i
  task automatic chk_ch(input string tag, input int i, input int c, input int e);
    chk({tag, "_cnt"}, cnt_of(i), c);
    chk({tag, "_err"}, err_of(i), e & 32'h1FF);
  endtask

  function automatic logic pat(input int p, input int x, input int w);
    return ((p > 0) && (w % p == 0)) || ((w % 2 == 1) && (w < 2 * x));
  endfunction

  // One clock: drive inputs, wait for the edge, sample 1 time unit later
  task automatic step();
    if (act) begin
      edge_pulse[0] = pat(per[0], x0, wc);
      edge_pulse[1] = pat(per[1], 0, wc);
      edge_pulse[2] = pat(per[2], 0, wc);
      edge_pulse[3] = pat(per[3], 0, wc);
      start = (wc == start_at);
    end else begin
      edge_pulse = '0;
    end
    @(posedge clk);
    #1;
    if (act) wc = (wc + 1) % win;
  endtask

  // Full window: no strobe until the last cycle, then exactly one strobe
  task automatic run_window(input string tag);
    int nmv = 0;
    for (int i = 0; i < win - 1; i++) begin
      step();
      if (meas_valid) nmv++;
    end
    step();
    chk({tag, "_early_mv"}, nmv, 0);
    chk({tag, "_mv"}, {31'd0, meas_valid}, 1);
  endtask

  task automatic idle_steps(input string tag, input int n);
    int nmv = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (meas_valid) nmv++;
    end
    chk({tag, "_no_mv"}, nmv, 0);
  endtask

  initial begin
    for (int i = 0; i < NUM_CH; i++) per[i] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_mv", {31'd0, meas_valid}, 0);
    chk("rst_count", meas_count, 0);
    chk("rst_err", meas_err[31:0], 0);
    chk("rst_sat", {28'd0, meas_sat}, 0);
    chk("rst_locked", {28'd0, locked}, 0);

    // Continuous mode, 100-cycle windows
    cfg_oneshot = 1'b0; cfg_win_len = 16'd100; cfg_target = 8'd50; cfg_tol = 8'd2;
    cfg_lock_thr = 4'd3; cfg_unlock_thr = 4'd2;
    per[0] = 2; per[1] = 3;
    enable = 1'b1;
    step();
    chk("start_busy", {31'd0, busy}, 1);
    act = 1'b1; wc = 0; win = 100;

    run_window("w1");
    chk_ch("w1_ch0", 0, 50, 0);
    chk_ch("w1_ch1", 1, 34, -16);
    chk_ch("w1_ch2", 2, 0, -50);
    chk("w1_sat", {28'd0, meas_sat}, 0);
    chk("w1_locked", {28'd0, locked}, 4'b0000);
    run_window("w2");
    chk("w2_locked", {28'd0, locked}, 4'b0000);
    run_window("w3");
    chk("w3_locked", {28'd0, locked}, 4'b0001);
    chk("w3_busy", {31'd0, busy}, 1);

    // Unlock hysteresis: one bad window is tolerated, two drop lock
    x0 = 10;
    run_window("w4");
    chk_ch("w4_ch0", 0, 60, 10);
    chk("w4_locked", {28'd0, locked}, 4'b0001);
    x0 = 0;
    run_window("w5");
    chk("w5_locked", {28'd0, locked}, 4'b0001);
    x0 = 10;
    run_window("w6");
    chk("w6_locked", {28'd0, locked}, 4'b0001);
    run_window("w7");
    chk("w7_locked", {28'd0, locked}, 4'b0000);

    // Abort at window cycle 50
    idle_steps("abort_pre", 50);
    enable = 1'b0;
    step();
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_mv", {31'd0, meas_valid}, 0);
    act = 1'b0;
    idle_steps("abort_post", 5);
    chk_ch("abort_ch0", 0, 60, 10);
    chk_ch("abort_ch1", 1, 34, -16);

    // Saturation over a 300-cycle window
    cfg_win_len = 16'd300; x0 = 0; per[2] = 1;
    enable = 1'b1;
    step();
    act = 1'b1; wc = 0; win = 300;
    run_window("sat");
    chk_ch("sat_ch0", 0, 150, 100);
    chk_ch("sat_ch1", 1, 100, 50);
    chk_ch("sat_ch2", 2, 255, 205);
    chk("sat_sat", {28'd0, meas_sat}, 4'b0100);
    chk("sat_locked", {28'd0, locked}, 4'b0000);

    // Back to idle, then one-shot: no window until start
    enable = 1'b0; act = 1'b0;
    step();
    cfg_oneshot = 1'b1; cfg_win_len = 16'd10;
    per[0] = 0; per[1] = 0; per[2] = 0; per[3] = 9;
    enable = 1'b1;
    idle_steps("os_wait", 3);
    chk("os_wait_busy", {31'd0, busy}, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("os_busy", {31'd0, busy}, 1);
    act = 1'b1; wc = 0; win = 10; start_at = 4;   // start while busy is ignored
    run_window("os1");
    chk_ch("os1_ch3", 3, 2, -48);
    chk_ch("os1_ch0", 0, 0, -50);
    chk("os1_sat", {28'd0, meas_sat}, 4'b0000);
    chk("os1_busy", {31'd0, busy}, 0);
    act = 1'b0; start_at = -1;
    idle_steps("os_done", 20);
    chk("os_done_busy", {31'd0, busy}, 0);
    chk_ch("os_done_ch3", 3, 2, -48);

    // Restart from DONE
    per[0] = 2;
    start = 1'b1;
    step();
    start = 1'b0;
    act = 1'b1; wc = 0;
    run_window("os2");
    chk_ch("os2_ch0", 0, 5, -45);
    chk_ch("os2_ch3", 3, 2, -48);

    // Asynchronous reset mid-window
    act = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    act = 1'b1; wc = 0;
    step(); step(); step();
    chk("pre_rst_busy", {31'd0, busy}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 0);
    chk("arst_count", meas_count, 0);
    chk("arst_err", meas_err[31:0], 0);
    chk("arst_locked", {28'd0, locked}, 0);
    act = 1'b0; edge_pulse = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("arst_mv", {31'd0, meas_valid}, 0);
    chk("arst_sat", {28'd0, meas_sat}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
